// File: rtl/glyph_rom_arbiter.sv
// rtl/glyph_rom_arbiter.sv - round-robin arbiter sharing one glyph ROM between two renderers
//
// Purpose:
//   Two requesters (VGA text renderer, RTC menu renderer) share a single
//   combinational 8-bit glyph ROM. Each request is one row read or a burst of
//   BURST_LEN rows. Ties are broken round-robin. The ROM address is driven
//   from registers, and the returned row is registered per requester with a
//   valid strobe. Single-read latency is two cycles, and bursts stream one
//   row per cycle.
//
// Ports:
//   clk               system clock, rising edge
//   rst               synchronous active-low reset
//   req0/req1         request, held until the matching gnt
//   burst0/burst1     1 = burst of BURST_LEN rows, 0 = single row
//   row0/row1         starting row (3 bits)
//   glyph0/glyph1     glyph select (4 bits)
//   gnt0/gnt1         combinational accept strobe
//   valid0/valid1     registered, data0/data1 carry a returned row
//   data0/data1       registered row data
//   rom_dir/rom_sel   registered ROM row address / glyph select
//   rom_data          combinational ROM output
//   busy              high while burst beats remain to be issued

module glyph_rom_arbiter #(
  parameter int BURST_LEN = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       req1,
  input  logic       burst0,
  input  logic       burst1,
  input  logic [2:0] row0,
  input  logic [2:0] row1,
  input  logic [3:0] glyph0,
  input  logic [3:0] glyph1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       valid0,
  output logic       valid1,
  output logic [7:0] data0,
  output logic [7:0] data1,
  output logic [2:0] rom_dir,
  output logic [3:0] rom_sel,
  input  logic [7:0] rom_data,
  output logic       busy
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  localparam logic [3:0] LP_BEATS_INIT = 4'(BURST_LEN - 1);
  localparam logic       LP_MULTI_BEAT = (BURST_LEN > 1);

  state_t     r_state, w_state_nxt;
  logic [3:0] r_beats_left, w_beats_nxt;
  logic       r_last, w_last_nxt;
  logic       r_owner, w_owner_nxt;
  logic       r_addr_v, w_addr_v_nxt;
  logic [2:0] r_rom_dir, w_dir_nxt;
  logic [3:0] r_rom_sel, w_sel_nxt;
  logic       r_valid0, r_valid1;
  logic [7:0] r_data0, r_data1;

  logic       w_pick0, w_pick1;
  logic       w_accept;
  logic       w_acc_burst;

  // Round-robin pick: r_last names the requester granted most recently.
  // On a tie the other requester wins. r_last resets to 1, so requester 0
  // wins the first tie.
  assign w_pick0 = req0 & (~req1 | r_last);
  assign w_pick1 = req1 & (~req0 | ~r_last);

  // Accepts happen only in IDLE. The last burst beat is addressed in the
  // first IDLE cycle after a burst, so a grant there follows the burst with
  // no idle bubble on the ROM address.
  assign w_accept    = rst & (r_state == ST_IDLE) & (req0 | req1);
  assign w_acc_burst = w_pick1 ? burst1 : burst0;

  assign gnt0 = w_accept & w_pick0;
  assign gnt1 = w_accept & w_pick1;

  always_comb begin
    w_state_nxt  = r_state;
    w_beats_nxt  = r_beats_left;
    w_last_nxt   = r_last;
    w_owner_nxt  = r_owner;
    w_addr_v_nxt = 1'b0;
    w_dir_nxt    = r_rom_dir;
    w_sel_nxt    = r_rom_sel;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_owner_nxt  = w_pick1;
          w_last_nxt   = w_pick1;
          w_dir_nxt    = w_pick1 ? row1 : row0;
          w_sel_nxt    = w_pick1 ? glyph1 : glyph0;
          w_addr_v_nxt = 1'b1;
          // A one-row burst is indistinguishable from a single read.
          if (w_acc_burst && LP_MULTI_BEAT) begin
            w_state_nxt = ST_BURST;
            w_beats_nxt = LP_BEATS_INIT;
          end
        end
      end
      ST_BURST: begin
        // The row address wraps naturally in 3 bits (7 -> 0).
        w_dir_nxt    = r_rom_dir + 3'd1;
        w_beats_nxt  = r_beats_left - 4'd1;
        w_addr_v_nxt = 1'b1;
        if (r_beats_left == 4'd1) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_beats_left <= 4'd0;
      r_last       <= 1'b1;
      r_owner      <= 1'b0;
      r_addr_v     <= 1'b0;
      r_rom_dir    <= 3'd0;
      r_rom_sel    <= 4'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_beats_left <= w_beats_nxt;
      r_last       <= w_last_nxt;
      r_owner      <= w_owner_nxt;
      r_addr_v     <= w_addr_v_nxt;
      r_rom_dir    <= w_dir_nxt;
      r_rom_sel    <= w_sel_nxt;
    end
  end

  // Return path: rom_data belongs to the owner of the address presented this
  // cycle. The non-owner keeps its last data and sees valid low.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_valid0 <= 1'b0;
      r_valid1 <= 1'b0;
      r_data0  <= 8'd0;
      r_data1  <= 8'd0;
    end else begin
      r_valid0 <= r_addr_v & ~r_owner;
      r_valid1 <= r_addr_v & r_owner;
      if (r_addr_v && !r_owner) begin
        r_data0 <= rom_data;
      end
      if (r_addr_v && r_owner) begin
        r_data1 <= rom_data;
      end
    end
  end

  assign valid0  = r_valid0;
  assign valid1  = r_valid1;
  assign data0   = r_data0;
  assign data1   = r_data1;
  assign rom_dir = r_rom_dir;
  assign rom_sel = r_rom_sel;
  assign busy    = (r_state == ST_BURST);

endmodule

// File: tb/tb_glyph_rom_arbiter.sv
// tb/tb_glyph_rom_arbiter.sv - self-checking bench for glyph_rom_arbiter
module tb_glyph_rom_arbiter;

  logic       clk;
  logic       rst;
  logic       req0, req1, burst0, burst1;
  logic [2:0] row0, row1;
  logic [3:0] glyph0, glyph1;
  logic       gnt0, gnt1, valid0, valid1, busy;
  logic [7:0] data0, data1, rom_data;
  logic [2:0] rom_dir;
  logic [3:0] rom_sel;

  int n_pass  = 0;
  int n_total = 0;

  function automatic logic [7:0] rom_fn(input logic [3:0] g, input logic [2:0] r);
    return {g, r, 1'b1} ^ 8'h3C;
  endfunction

  assign rom_data = rom_fn(rom_sel, rom_dir);

  glyph_rom_arbiter #(.BURST_LEN(8)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .burst0(burst0), .burst1(burst1),
    .row0(row0), .row1(row1), .glyph0(glyph0), .glyph1(glyph1),
    .gnt0(gnt0), .gnt1(gnt1), .valid0(valid0), .valid1(valid1),
    .data0(data0), .data1(data1), .rom_dir(rom_dir), .rom_sel(rom_sel),
    .rom_data(rom_data), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       who;
    logic [2:0] row;
    logic [3:0] glyph;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [2:0] dir_e;
    vecs[0] = '{1'b0, 3'd3, 4'd5,  8'h6B};
    vecs[1] = '{1'b1, 3'd0, 4'd0,  8'h3D};
    vecs[2] = '{1'b0, 3'd7, 4'd15, 8'hC3};
    vecs[3] = '{1'b1, 3'd5, 4'd10, 8'h97};
    vecs[4] = '{1'b0, 3'd1, 4'd9,  8'hAF};
    vecs[5] = '{1'b1, 3'd6, 4'd3,  8'h01};

    rst = 1'b0; req0 = 1'b1; req1 = 1'b1; burst0 = 1'b0; burst1 = 1'b0;
    row0 = 3'd2; glyph0 = 4'd4; row1 = 3'd4; glyph1 = 4'd7;

    // Reset held for two cycles with both requesting.
    step();
    @(negedge clk);
    chk("rst_gnt0", gnt0, 0);   chk("rst_gnt1", gnt1, 0);
    chk("rst_valid0", valid0, 0); chk("rst_valid1", valid1, 0);
    chk("rst_data0", data0, 0); chk("rst_data1", data1, 0);
    chk("rst_dir", rom_dir, 0); chk("rst_sel", rom_sel, 0);
    chk("rst_busy", busy, 0);
    step();
    @(negedge clk);
    chk("rst2_gnt0", gnt0, 0); chk("rst2_gnt1", gnt1, 0);
    step();
    rst = 1'b1;

    // Contention: both held, grants alternate starting with requester 0.
    for (int k = 0; k < 6; k++) begin
      if (k == 4) begin req0 = 1'b0; req1 = 1'b0; end
      @(negedge clk);
      chk("cont_gnt0", gnt0, (k < 4) && (k % 2 == 0));
      chk("cont_gnt1", gnt1, (k < 4) && (k % 2 == 1));
      chk("cont_valid0", valid0, (k == 2) || (k == 4));
      chk("cont_valid1", valid1, (k == 3) || (k == 5));
      if (k == 2 || k == 4) chk("cont_data0", data0, 8'h79);
      if (k == 3 || k == 5) chk("cont_data1", data1, 8'h45);
      step();
    end

    // Table-driven single reads.
    for (int i = 0; i < 6; i++) begin
      if (vecs[i].who) begin
        req1 = 1'b1; row1 = vecs[i].row; glyph1 = vecs[i].glyph;
      end else begin
        req0 = 1'b1; row0 = vecs[i].row; glyph0 = vecs[i].glyph;
      end
      @(negedge clk);
      chk("vec_gnt0", gnt0, !vecs[i].who);
      chk("vec_gnt1", gnt1, vecs[i].who);
      step();
      req0 = 1'b0; req1 = 1'b0;
      @(negedge clk);
      chk("vec_dir", rom_dir, vecs[i].row);
      chk("vec_sel", rom_sel, vecs[i].glyph);
      chk("vec_early_valid", valid0 | valid1, 0);
      step();
      @(negedge clk);
      chk("vec_valid0", valid0, !vecs[i].who);
      chk("vec_valid1", valid1, vecs[i].who);
      chk("vec_data", vecs[i].who ? data1 : data0, vecs[i].exp);
      step();
      @(negedge clk);
      chk("vec_valid_drop", valid0 | valid1, 0);
      step();
    end

    // Burst with row wrap on requester 1.
    req1 = 1'b1; burst1 = 1'b1; row1 = 3'd6; glyph1 = 4'd2;
    @(negedge clk);
    chk("bw_gnt1", gnt1, 1);
    step();
    req1 = 1'b0; burst1 = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k <= 8) begin
        dir_e = 3'(6 + k - 1);
        chk("bw_dir", rom_dir, dir_e);
        chk("bw_sel", rom_sel, 4'd2);
      end
      chk("bw_busy", busy, k <= 7);
      chk("bw_valid1", valid1, (k >= 2) && (k <= 9));
      if (k >= 2 && k <= 9) begin
        dir_e = 3'(6 + k - 2);
        chk("bw_data1", data1, rom_fn(4'd2, dir_e));
      end
      step();
    end

    // Burst blocking and back-to-back grant.
    req0 = 1'b1; burst0 = 1'b1; row0 = 3'd1; glyph0 = 4'd3;
    @(negedge clk);
    chk("bb_gnt0", gnt0, 1);
    step();
    req0 = 1'b0; burst0 = 1'b0; row1 = 3'd5; glyph1 = 4'd9; burst1 = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      req1 = (k <= 8);
      @(negedge clk);
      chk("bb_gnt1", gnt1, k == 8);
      if (k <= 8) begin
        dir_e = 3'(1 + k - 1);
        chk("bb_dir0", rom_dir, dir_e);
      end
      if (k == 9) begin
        chk("bb_dir1", rom_dir, 3'd5);
        chk("bb_sel1", rom_sel, 4'd9);
      end
      chk("bb_valid0", valid0, (k >= 2) && (k <= 9));
      chk("bb_valid1", valid1, k == 10);
      if (k == 10) chk("bb_data1", data1, rom_fn(4'd9, 3'd5));
      step();
    end

    // Reset on the fourth burst beat.
    req0 = 1'b1; burst0 = 1'b1; row0 = 3'd0; glyph0 = 4'd1;
    @(negedge clk);
    chk("rm_gnt0", gnt0, 1);
    step();
    req0 = 1'b0; burst0 = 1'b0;
    step(); step(); step();
    rst = 1'b0;
    @(negedge clk);
    chk("rm_valid_pre", valid0, 1);
    chk("rm_dir_pre", rom_dir, 3'd3);
    step();
    @(negedge clk);
    chk("rm_valid0", valid0, 0);
    chk("rm_busy", busy, 0);
    chk("rm_dir", rom_dir, 0);
    step();
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rm_post_valid0", valid0, 0);
      chk("rm_post_busy", busy, 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
